// File: rtl/ped_signal_controller.sv
// Pedestrian WALK / DON'T WALK stage fed by the vehicle lamp outputs of the traffic light controller.
// Optional countdown display: define PED_COUNTDOWN_EN to expose the live interval counter.
module ped_signal_controller #(
  parameter int unsigned WALK_CYCLES  = 8,
  parameter int unsigned CLEAR_CYCLES = 4,
  parameter int unsigned CNT_W        = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             red,
  input  logic             yellow,
  input  logic             green,
  input  logic             ped_req,
  output logic             walk,
  output logic             dont_walk,
  output logic             req_pending,
  output logic [CNT_W-1:0] countdown,
  output logic             fault
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WALK  = 2'd1,
    ST_CLEAR = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             flash_q, flash_d;

  logic red_only, prep, illegal;

  assign red_only = red & ~yellow & ~green;
  assign prep     = red & yellow & ~green;
  assign illegal  = (green & red) | (green & yellow) | (~red & ~yellow & ~green);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      flash_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      flash_q <= flash_d;
    end
  end

  // Next-state, counter, request latch and flash phase
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    flash_d = flash_q;

    // A press while already walking is being served, so it is not latched
    if (ped_req && (state_q != ST_WALK)) begin
      req_d = 1'b1;
    end

    if (illegal) begin
      state_d = ST_FAULT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_q && red_only) begin
            state_d = ST_WALK;
            cnt_d   = WALK_LOAD;
            req_d   = 1'b0;
          end
        end
        ST_WALK: begin
          if (green || !red) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (prep || (cnt_q == '0)) begin
            state_d = ST_CLEAR;
            cnt_d   = CLEAR_LOAD;
            flash_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_CLEAR: begin
          flash_d = ~flash_q;
          if (green || (cnt_q == '0)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_FAULT: begin
          cnt_d = '0;
          if (red_only) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // walk is gated by the live inputs so it drops the instant red-only is lost
  assign walk        = (state_q == ST_WALK) & red_only;
  assign dont_walk   = (state_q == ST_CLEAR) ? flash_q : ~walk;
  assign req_pending = req_q;
  assign fault       = (state_q == ST_FAULT);

`ifdef PED_COUNTDOWN_EN
  assign countdown = ((state_q == ST_WALK) || (state_q == ST_CLEAR)) ? cnt_q : '0;
`else
  assign countdown = '0;
`endif

endmodule

// File: tb/tb_ped_signal_controller.sv
// Bench for ped_signal_controller: directed scenarios with literal expectations, then randomized
// lamp/press traffic checked every cycle against an interval-counting reference model.
module tb_ped_signal_controller;

  localparam int unsigned WALK_CYCLES  = 8;
  localparam int unsigned CLEAR_CYCLES = 4;
  localparam int unsigned CNT_W        = 4;
`ifdef PED_COUNTDOWN_EN
  localparam bit CD_EN = 1'b1;
`else
  localparam bit CD_EN = 1'b0;
`endif

  logic             clk     = 1'b0;
  logic             rst_n   = 1'b0;
  logic             red     = 1'b0;
  logic             yellow  = 1'b0;
  logic             green   = 1'b0;
  logic             ped_req = 1'b0;
  logic             walk;
  logic             dont_walk;
  logic             req_pending;
  logic [CNT_W-1:0] countdown;
  logic             fault;

  always #5 clk = ~clk;

  ped_signal_controller #(
    .WALK_CYCLES (WALK_CYCLES),
    .CLEAR_CYCLES(CLEAR_CYCLES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .red        (red),
    .yellow     (yellow),
    .green      (green),
    .ped_req    (ped_req),
    .walk       (walk),
    .dont_walk  (dont_walk),
    .req_pending(req_pending),
    .countdown  (countdown),
    .fault      (fault)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: remaining cycles of the WALK / clearance interval (0 = not in it)
  int m_walk_left;
  int m_clear_left;
  bit m_fault;
  bit m_pend;

  int s_walk, s_dw, s_req, s_cd, s_fault;

  function automatic void model_reset();
    m_walk_left  = 0;
    m_clear_left = 0;
    m_fault      = 1'b0;
    m_pend       = 1'b0;
  endfunction

  function automatic void model_step();
    bit ro, pr, il, walking, pend_before;
    ro          = red & !yellow & !green;
    pr          = red & yellow & !green;
    il          = (green & red) | (green & yellow) | (!red & !yellow & !green);
    walking     = (m_walk_left > 0);
    pend_before = m_pend;
    if (ped_req && !walking) m_pend = 1'b1;
    if (il) begin
      m_fault      = 1'b1;
      m_walk_left  = 0;
      m_clear_left = 0;
    end else if (m_fault) begin
      if (ro) m_fault = 1'b0;
    end else if (walking) begin
      if (green || !red) begin
        m_walk_left = 0;
      end else if (pr || (m_walk_left == 1)) begin
        m_walk_left  = 0;
        m_clear_left = int'(CLEAR_CYCLES);
      end else begin
        m_walk_left = m_walk_left - 1;
      end
    end else if (m_clear_left > 0) begin
      if (green || (m_clear_left == 1)) m_clear_left = 0;
      else m_clear_left = m_clear_left - 1;
    end else if (pend_before && ro) begin
      m_walk_left = int'(WALK_CYCLES);
      m_pend      = 1'b0;
    end
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    int e_walk, e_dw, e_cd;
    n_vec++;
    e_walk = ((m_walk_left > 0) && red && !yellow && !green) ? 1 : 0;
    if (m_clear_left > 0)
      e_dw = (((int'(CLEAR_CYCLES) - m_clear_left) % 2) == 0) ? 1 : 0;
    else
      e_dw = (e_walk == 1) ? 0 : 1;
    if (!CD_EN)                 e_cd = 0;
    else if (m_walk_left > 0)   e_cd = m_walk_left - 1;
    else if (m_clear_left > 0)  e_cd = m_clear_left - 1;
    else                        e_cd = 0;
    chk("walk", s_walk, e_walk);
    chk("dont_walk", s_dw, e_dw);
    chk("req_pending", s_req, int'(m_pend));
    chk("countdown", s_cd, e_cd);
    chk("fault", s_fault, int'(m_fault));
    chk("walk_and_dont_walk", 32'(walk & dont_walk), 0);
  endtask

  // One clock: drive at the falling edge, sample 1 time unit later, advance the model at the rising edge
  task automatic cycle(input logic r, input logic y, input logic g, input logic p,
                       input logic rn = 1'b1);
    @(negedge clk);
    rst_n   = rn;
    red     = r;
    yellow  = y;
    green   = g;
    ped_req = p;
    if (!rn) model_reset();
    #1;
    s_walk  = 32'(walk);
    s_dw    = 32'(dont_walk);
    s_req   = 32'(req_pending);
    s_cd    = 32'(countdown);
    s_fault = 32'(fault);
    compare_all();
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
  endtask

  initial begin
    int walk_cnt;
    logic [2:0] pat;
    model_reset();

    // Reset values
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_walk", s_walk, 0);
    chk("rst_dont_walk", s_dw, 1);
    chk("rst_req", s_req, 0);
    chk("rst_countdown", s_cd, 0);
    chk("rst_fault", s_fault, 0);

    // Red held without a press never grants WALK
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("idle_walk", s_walk, 0);
    chk("idle_req", s_req, 0);

    // Press during green, then a full WALK and clearance under steady red
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    walk_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      walk_cnt += s_walk;
      if (i == 0) chk("full_req_latched", s_req, 1);
      if (i == 1) begin
        chk("full_req_cleared", s_req, 0);
        chk("full_cd_first", s_cd, CD_EN ? 7 : 0);
      end
      if (i == 8) chk("full_cd_last", s_cd, 0);
      if (i >= 9 && i <= 12) chk("full_flash", s_dw, i % 2);
      if (i == 13) chk("full_idle_dw", s_dw, 1);
    end
    chk("full_walk_len", walk_cnt, 8);

    // PREP aborts WALK at countdown 4
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    chk("prep_walk_drop", s_walk, 0);
    chk("prep_cd_before", s_cd, CD_EN ? 4 : 0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    chk("prep_clear_cd", s_cd, CD_EN ? 3 : 0);
    chk("prep_clear_dw", s_dw, 1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);

    // Green aborts WALK straight to IDLE with no flash
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("green_walk_before", s_walk, 1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("green_walk_drop", s_walk, 0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("green_idle_dw", s_dw, 1);
    chk("green_idle_cd", s_cd, 0);

    // Illegal red+green: FAULT, latched press, recovery then WALK
    cycle(1'b1, 1'b0, 1'b1, 1'b1);
    chk("fault_before", s_fault, 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("fault_set", s_fault, 1);
    chk("fault_walk", s_walk, 0);
    chk("fault_dw", s_dw, 1);
    chk("fault_req", s_req, 1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("fault_exit", s_fault, 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("fault_then_walk", s_walk, 1);

    // Reset in the middle of clearance with a request pending
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("midclr_req", s_req, 1);
    chk("midclr_dw", s_dw, 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("midrst_walk", s_walk, 0);
    chk("midrst_dw", s_dw, 1);
    chk("midrst_req", s_req, 0);
    chk("midrst_cd", s_cd, 0);
    chk("midrst_fault", s_fault, 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("postrst_walk", s_walk, 0);

    // Randomized lamp sequences and presses
    pat = 3'b100;
    for (int i = 0; i < 4000; i++) begin
      int k;
      if ($urandom_range(0, 99) < 15) begin
        k = int'($urandom_range(0, 99));
        if (k < 45)      pat = 3'b100;
        else if (k < 60) pat = 3'b110;
        else if (k < 75) pat = 3'b001;
        else if (k < 85) pat = 3'b010;
        else begin
          case ($urandom_range(0, 3))
            0:       pat = 3'b000;
            1:       pat = 3'b101;
            2:       pat = 3'b011;
            default: pat = 3'b111;
          endcase
        end
      end
      cycle(pat[2], pat[1], pat[0], ($urandom_range(0, 99) < 15),
            ($urandom_range(0, 299) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
